// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
//   adder_op_e      : operation select (add / subtract)
//   stages()        : number of pipeline stages for a given data/chunk width
//   DEF_DATA_WIDTH  : default operand width
//   DEF_CHUNK_WIDTH : default bits added per stage
package adder_pkg;

  typedef enum logic {OP_ADD, OP_SUB} adder_op_e;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_CHUNK_WIDTH = 4;

  function automatic int unsigned stages(input int unsigned data_width,
                                         input int unsigned chunk_width);
    return data_width / chunk_width;
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// One pipeline stage of the chunked adder: adds a CHUNK_WIDTH slice plus carry and
// registers the sum chunk, the carry out and the signed-overflow indication of the slice.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   en              : stage advance; registers hold when low
//   a, b, c_in      : slice operands (b already inverted for subtract) and carry in
//   sum, c_out, ovf : registered slice sum, carry out and signed overflow
module adder_pipe_slice #(
  parameter int unsigned CHUNK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   c_in,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   c_out,
  output logic                   ovf
);

  logic [CHUNK_WIDTH:0]   full;
  logic                   c_msb;
  logic [CHUNK_WIDTH-1:0] sum_q;
  logic                   c_out_q;
  logic                   ovf_q;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, c_in};
    // Carry into the MSB recovered from the MSB sum bit; overflow is carry-in xor carry-out
    // there. Only meaningful for the slice holding the word MSB.
    c_msb = full[CHUNK_WIDTH-1] ^ a[CHUNK_WIDTH-1] ^ b[CHUNK_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      sum_q   <= full[CHUNK_WIDTH-1:0];
      c_out_q <= full[CHUNK_WIDTH];
      ovf_q   <= c_msb ^ full[CHUNK_WIDTH];
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit with valid/ready handshaking on both sides.
// DATA_WIDTH is split into CHUNK_WIDTH slices, one slice per stage, carry registered
// between stages; latency is DATA_WIDTH/CHUNK_WIDTH cycles at one operation per cycle.
// The whole pipe stalls when the output holds a result the consumer has not taken.
// Optional build macro: ADDER_PIPE_SAT_EN -- saturate sum to the signed limit on overflow.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b, c_in, sub      : operands, carry in (add only), 1 = subtract
//   out_valid, out_ready : result handshake
//   sum, c_out, ovf      : result, carry out (no-borrow in subtract), signed overflow
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  c_in,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  c_out,
  output logic                  ovf
);

  localparam int unsigned STAGES = stages(DATA_WIDTH, CHUNK_WIDTH);

  adder_op_e             op;
  logic                  advance;
  logic [DATA_WIDTH-1:0] b_eff;
  logic                  c_first;

  logic [STAGES-1:0]     valid_q;
  // Operand bits not yet consumed, shifted so the next stage's chunk sits at bit 0.
  logic [DATA_WIDTH-1:0] a_skew_q [STAGES];
  logic [DATA_WIDTH-1:0] b_skew_q [STAGES];
  // Sum chunks already completed by earlier stages, kept in their final bit positions.
  logic [DATA_WIDTH-1:0] lo_q     [STAGES];
  logic [DATA_WIDTH-1:0] stage_sum [STAGES];

  logic [CHUNK_WIDTH-1:0] slice_a   [STAGES];
  logic [CHUNK_WIDTH-1:0] slice_b   [STAGES];
  logic [STAGES-1:0]      slice_ci;
  logic [CHUNK_WIDTH-1:0] chunk_sum [STAGES];
  logic [STAGES-1:0]      chunk_c;
  logic [STAGES-1:0]      chunk_ovf;

  logic [DATA_WIDTH-1:0] sum_raw;

  assign op       = sub ? OP_SUB : OP_ADD;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    b_eff   = b;
    c_first = c_in;
    if (op == OP_SUB) begin
      b_eff   = ~b;
      c_first = 1'b1;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign slice_a[s]  = a[CHUNK_WIDTH-1:0];
      assign slice_b[s]  = b_eff[CHUNK_WIDTH-1:0];
      assign slice_ci[s] = c_first;
    end else begin : g_rest
      assign slice_a[s]  = a_skew_q[s-1][CHUNK_WIDTH-1:0];
      assign slice_b[s]  = b_skew_q[s-1][CHUNK_WIDTH-1:0];
      assign slice_ci[s] = chunk_c[s-1];
    end

    adder_pipe_slice #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a     (slice_a[s]),
      .b     (slice_b[s]),
      .c_in  (slice_ci[s]),
      .sum   (chunk_sum[s]),
      .c_out (chunk_c[s]),
      .ovf   (chunk_ovf[s])
    );

    assign stage_sum[s] = lo_q[s] | (DATA_WIDTH'(chunk_sum[s]) << (s * CHUNK_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_skew_q[s] <= '0;
        b_skew_q[s] <= '0;
        lo_q[s]     <= '0;
      end
    end else if (advance) begin
      valid_q[0]  <= in_valid;
      a_skew_q[0] <= a >> CHUNK_WIDTH;
      b_skew_q[0] <= b_eff >> CHUNK_WIDTH;
      lo_q[0]     <= '0;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s]  <= valid_q[s-1];
        a_skew_q[s] <= a_skew_q[s-1] >> CHUNK_WIDTH;
        b_skew_q[s] <= b_skew_q[s-1] >> CHUNK_WIDTH;
        lo_q[s]     <= stage_sum[s-1];
      end
    end
  end

  assign sum_raw   = stage_sum[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign c_out     = chunk_c[STAGES-1];
  assign ovf       = chunk_ovf[STAGES-1];

`ifdef ADDER_PIPE_SAT_EN
  // On overflow the raw MSB is the inverse of the true sign: MSB set means the true
  // result is positive.
  always_comb begin
    sum = sum_raw;
    if (ovf) begin
      sum = sum_raw[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                  : {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  assign sum = sum_raw;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
`timescale 1ns/1ps
module tb_adder_pipe;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          c_in;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          c_out;
  logic          ovf;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          c_out;
    logic          ovf;
  } res_t;

  res_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   last_pop = -1;
  int   prev_pop = -1;
  int   pops     = 0;
  logic last_acc = 1'b0;

  adder_pipe #(
    .DATA_WIDTH  (16),
    .CHUNK_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                 input logic ci, input logic s);
    logic [DW-1:0] yb;
    logic [DW:0]   t;
    res_t          r;
    yb      = s ? ~y : y;
    t       = {1'b0, x} + {1'b0, yb} + (s ? 17'd1 : {16'd0, ci});
    r.sum   = t[DW-1:0];
    r.c_out = t[DW];
    r.ovf   = (x[DW-1] == yb[DW-1]) && (t[DW-1] != x[DW-1]);
`ifdef ADDER_PIPE_SAT_EN
    if (r.ovf) r.sum = x[DW-1] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare any output transfer, record any accept, then advance past the edge.
  task automatic cycle();
    res_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.sum});
        chk("c_out", {31'd0, c_out}, {31'd0, e.c_out});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        prev_pop = last_pop;
        last_pop = cyc;
        pops++;
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb.push_back(model(a, b, c_in, sub));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic ci, input logic s);
    a        = x;
    b        = y;
    c_in     = ci;
    sub      = s;
    in_valid = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    cycle();
    cycle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Basic add with latency check
    drive(16'd1, 16'd1, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat_wait", {31'd0, out_valid}, 32'd0);
      cycle();
    end
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_sum", {16'd0, sum}, 32'h3);
    drain(8);

    // Full carry ripple
    drive(16'h00FF, 16'h0000, 1'b1, 1'b0);
    cycle();
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    drain(10);

    // Full-rate accepts, results on consecutive cycles
    drive(16'd10, 16'd10, 1'b0, 1'b0);
    cycle();
    drive(16'd50, 16'd60, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    drain(10);
    chk("back_to_back", last_pop - prev_pop, 32'd1);

    // Subtract without and with overflow
    drive(16'd5, 16'd7, 1'b1, 1'b1);
    cycle();
    drive(16'h8000, 16'd1, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    drain(10);

    // Stall with a full pipe
    p0        = pops;
    out_ready = 1'b0;
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    cycle();
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    cycle();
    drive(16'h0F0F, 16'h00F1, 1'b1, 1'b1);
    cycle();
    drive(16'hABCD, 16'h5432, 1'b1, 1'b0);
    cycle();
    drive(16'h4444, 16'h2222, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sum", {16'd0, sum}, {16'd0, sb[0].sum});
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain(20);
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_pops", pops - p0, 32'd5);

    // Reset with three operations in flight
    drive(16'd100, 16'd200, 1'b0, 1'b0);
    cycle();
    drive(16'd300, 16'd400, 1'b0, 1'b0);
    cycle();
    drive(16'd500, 16'd600, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    rst_n = 1'b1;
    sb.delete();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    drive(16'd1, 16'd1, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_wait", {31'd0, out_valid}, 32'd0);
      cycle();
    end
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_sum", {16'd0, sum}, 32'h3);
    drain(8);

    // Random operands with random consumer back-pressure
    for (int n = 0; n < 24; n++) begin
      drive(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
      last_acc = 1'b0;
      for (int t = 0; t < 20 && !last_acc; t++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      chk("rand_accept", {31'd0, last_acc}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational ripple adder. Splits DATA_WIDTH into CHUNK_WIDTH slices, one slice per pipeline stage; the carry is registered between stages.
- Adds a subtract mode, a signed-overflow flag and valid/ready handshaking on both sides.
- Sits between operand producers and result consumers; throughput is one operation per cycle.

Parameters:
- DATA_WIDTH, 16, operand/result width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4, bits added per stage; STAGES = DATA_WIDTH/CHUNK_WIDTH (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  DATA_WIDTH  operand a
- b  in  DATA_WIDTH  operand b
- c_in  in  1  carry in; used in add mode only
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result this cycle
- sum  out  DATA_WIDTH  result
- c_out  out  1  carry out of MSB; in sub mode, 1 = no borrow
- ovf  out  1  signed overflow

Behaviour:
- Reset: one clock, one synchronous active-low reset (rst_n sampled on rising clk edge).
  - While rst_n = 0 at an edge: all stage valid bits, out_valid, sum, c_out and ovf are cleared to 0.
  - in_ready is combinational and reads 1 during reset.
- Arithmetic:
  - add: {c_out, sum} = a + b + c_in
  - sub: {c_out, sum} = a + ~b + 1; c_in is ignored.
  - ovf = (opA[MSB] == opB'[MSB]) && (sum[MSB] != opA[MSB]), where opB' is b or ~b as applied.
- Pipeline:
  - Stage k (1..STAGES) adds chunk k-1 with the carry registered by stage k-1. Stage 1 takes its carry from c_in (add) or 1 (sub).
  - Upper operand chunks travel skewed with the data; completed lower sum chunks are delayed so the final sum is aligned.
- Latency and throughput:
  - Latency is STAGES cycles. An operation accepted at edge N appears with out_valid = 1 after edge N+STAGES, given no stall.
  - Back-to-back accepts produce back-to-back results in order.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Operation accepted when in_valid && in_ready.
  - When advance = 0 the whole pipe freezes. sum, c_out, ovf and out_valid hold stable until out_ready = 1.
  - Bubbles propagate as valid = 0 slices. There is no bubble collapsing; the global stall is the decided behaviour.
- Simultaneous events:
  - Accept and output transfer in the same cycle are legal; full rate is sustained.
  - in_valid while in_ready = 0 has no effect, and the producer must hold its inputs.
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 after the reset edge, and the first post-reset accept follows the normal latency.
- Wrap-around: results are modulo 2^DATA_WIDTH. The carry is reported only on c_out.
- out data while out_valid = 0 is don't-care, but must be deterministic (zero after reset).

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN
- Defined:
  - When ovf = 1, sum saturates to the signed limit: 0111…1 if the true result is positive, 1000…0 if negative.
  - ovf and c_out still report the raw result.
  - Saturation happens in the final stage and adds no latency.
- Undefined: sum is the raw wrapped result, and the saturation logic is absent.

Decomposition:
- Package adder_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} adder_op_e
  - function stages(data_width, chunk_width) returning the stage count
  - localparam DEF_DATA_WIDTH = 16, DEF_CHUNK_WIDTH = 4
- Sub-module adder_pipe_slice: one CHUNK_WIDTH adder with registered sum chunk and carry, plus an enable (advance) input. It is instantiated STAGES times via generate.

Test Plan (DATA_WIDTH = 16, CHUNK_WIDTH = 4, latency 4):
- Basic add: a=1, b=1, c_in=1, add, out_ready=1 -> sum=16'h0003, c_out=0, ovf=0, out_valid 4 cycles after accept.
- Full carry ripple: a=16'h00FF, b=0, c_in=1 -> sum=16'h0100. Then a=16'hFFFF, b=0, c_in=1 -> sum=16'h0000, c_out=1.
- Full-rate accepts: 10+10+0 then 50+60+1 on consecutive cycles -> sum=20 then sum=111 on consecutive cycles, in order.
- Subtract, no overflow: a=5, b=7, sub, c_in=1 -> sum=16'hFFFE, c_out=0, ovf=0.
- Subtract, overflow: a=16'h8000, b=1, sub -> c_out=1, ovf=1; sum=16'h7FFF, or 16'h8000 with ADDER_PIPE_SAT_EN.
- Stall: pipe full, out_ready=0 for 3 cycles -> in_ready=0 and outputs stable across all 3 cycles. On release, all 4 results drain in order with none lost or duplicated.
- Reset mid-operation: rst_n=0 for 1 cycle with 3 operations in flight -> out_valid=0 next cycle and no stale result emerges. A new 1+1+1 yields 3 after 4 cycles.
